// File: rtl/fire_pkg.sv
// Shared definitions for the fire controller and the extinguisher it drives.
package fire_pkg;

    // Zone addressing shared with the extinguisher: one zone per position code.
    localparam int DEFAULT_POS_W = 3;
    localparam int DEFAULT_ZONES = 2 ** DEFAULT_POS_W;

    // Supervisory state, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPRAY  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/fire_controller_zone_mask.sv
// Pending-zone register: new detections are OR-ed in, a sprayed zone is
// cleared, and a detection wins over a clear on the same zone and cycle.
module zone_mask
    import fire_pkg::*;
#(
    parameter  int POS_W = DEFAULT_POS_W,
    localparam int ZONES = 2 ** POS_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [ZONES-1:0] set_vec,
    input  logic             clr_en,
    input  logic [POS_W-1:0] clr_idx,
    output logic [ZONES-1:0] pend,
    output logic [ZONES-1:0] pend_nxt
);

    logic [ZONES-1:0] clr_bit;
    logic [ZONES-1:0] pend_reg;

    // One-hot decode of the sprayed position; every code maps to a zone.
    generate
        for (genvar gi = 0; gi < ZONES; gi++) begin : g_clr_bit
            assign clr_bit[gi] = clr_en && (clr_idx == POS_W'(gi));
        end
    endgenerate

    // Set after clear so a fresh detection survives a same-cycle spray.
    assign pend_nxt = (pend_reg & ~clr_bit) | set_vec;
    assign pend     = pend_reg;

    // Pending register, updated in every controller state.
    always_ff @(posedge clk) begin
        if (clr) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_nxt;
        end
    end

endmodule

// File: rtl/fire_controller.sv
// Extinguisher supervisor: latches fire zones, enables the sweep, waits out a
// quiet verify window and reports completion, or latches a fault when the
// extinguisher stalls or fails to put the fire out.
module fire_controller
    import fire_pkg::*;
#(
    parameter  int POS_W         = DEFAULT_POS_W,
    parameter  int VERIFY_CYCLES = 32,
    parameter  int MAX_PASSES    = 4,
    parameter  int WDOG_CYCLES   = 64,
    localparam int ZONES         = 2 ** POS_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [ZONES-1:0] fire_zone,
    input  logic             ext_active,
    input  logic [POS_W-1:0] ext_position,
    output logic             ext_enable,
    output logic [ZONES-1:0] zone_pending,
    output logic             alarm,
    output logic             done,
    output logic             fault
);

    localparam int VCNT_W = (VERIFY_CYCLES > 1) ? $clog2(VERIFY_CYCLES) : 1;
    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(VERIFY_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_MAX  = PASS_W'(MAX_PASSES);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);

    state_t              state_reg, state_next;
    logic [VCNT_W-1:0]   vcnt_reg, vcnt_next;
    logic [PASS_W-1:0]   passes_reg, passes_next;
    logic [WDOG_W-1:0]   wdog_reg, wdog_next;
    logic                act_prev_reg, act_prev_next;
    logic                ext_enable_reg, alarm_reg, done_reg, fault_reg;
    logic                ext_enable_next, alarm_next, done_next, fault_next;
    logic [ZONES-1:0]    pend_nxt;
    logic                spray_clr;

    // Feedback only counts while spraying; held values outside SPRAY are stale.
    assign spray_clr = (state_reg == ST_SPRAY) && ext_active;

    zone_mask #(.POS_W(POS_W)) u_zone_mask (
        .clk      (clk),
        .clr      (clr),
        .set_vec  (fire_zone),
        .clr_en   (spray_clr),
        .clr_idx  (ext_position),
        .pend     (zone_pending),
        .pend_nxt (pend_nxt)
    );

    // Next-state, saturating counters and registered-output decode.
    always_comb begin
        state_next    = state_reg;
        vcnt_next     = vcnt_reg;
        passes_next   = passes_reg;
        wdog_next     = wdog_reg;
        act_prev_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pend_nxt != '0) begin
                    state_next  = ST_SPRAY;
                    passes_next = '0;
                    wdog_next   = '0;
                end
            end
            ST_SPRAY: begin
                act_prev_next = ext_active;
                // A 1->0 transition of ext_active marks the end of one sweep.
                if (act_prev_reg && !ext_active && passes_reg != PASS_MAX) begin
                    passes_next = passes_reg + 1'b1;
                end
                if (ext_active) begin
                    wdog_next = '0;
                end else if (wdog_reg != WDOG_MAX) begin
                    wdog_next = wdog_reg + 1'b1;
                end
                // Fault outranks the transition to VERIFY.
                if (wdog_next == WDOG_MAX ||
                    (passes_next == PASS_MAX && pend_nxt != '0)) begin
                    state_next = ST_FAULT;
                end else if (pend_nxt == '0) begin
                    state_next = ST_VERIFY;
                    vcnt_next  = '0;
                end
            end
            ST_VERIFY: begin
                if (fire_zone != '0) begin
                    state_next  = ST_SPRAY;
                    vcnt_next   = '0;
                    passes_next = '0;
                    wdog_next   = '0;
                end else if (vcnt_reg == VCNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    vcnt_next = vcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
        ext_enable_next = (state_next == ST_SPRAY);
        alarm_next      = (state_next != ST_IDLE);
        fault_next      = (state_next == ST_FAULT);
        done_next       = (state_reg == ST_VERIFY) && (state_next == ST_IDLE);
    end

    // State, counters and outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= ST_IDLE;
            vcnt_reg       <= '0;
            passes_reg     <= '0;
            wdog_reg       <= '0;
            act_prev_reg   <= 1'b0;
            ext_enable_reg <= 1'b0;
            alarm_reg      <= 1'b0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vcnt_reg       <= vcnt_next;
            passes_reg     <= passes_next;
            wdog_reg       <= wdog_next;
            act_prev_reg   <= act_prev_next;
            ext_enable_reg <= ext_enable_next;
            alarm_reg      <= alarm_next;
            done_reg       <= done_next;
            fault_reg      <= fault_next;
        end
    end

    assign ext_enable = ext_enable_reg;
    assign alarm      = alarm_reg;
    assign done       = done_reg;
    assign fault      = fault_reg;

endmodule
